output_port_arbiter: RTL and testbench

- Per-output-port switch allocator for the 5-port mesh router. It sits downstream of the five per-input LBDR units and consumes their port-request bits for this one output direction.
- Round-robin arbitration across requesting inputs with packet lock: the grant is issued on a HEADER flit and held until that packet's TAIL flit transfers.
- Credit-based flow control toward the neighbour's input buffer; emits FIFO pop strobes and the crossbar select.

---
 rtl/output_port_arbiter_pkg.sv | 34 +++
 rtl/output_port_arbiter_if.sv | 40 ++++
 rtl/output_port_arbiter_rr_arbiter.sv | 34 +++
 rtl/output_port_arbiter.sv | 132 +++++++++++++
 tb/tb_output_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/output_port_arbiter_pkg.sv
// Shared definitions for the mesh-router output arbiters: flit id encodings,
// arbiter FSM states, port index constants and a small pointer helper.
package output_port_arbiter_pkg;

    localparam int FLIT_ID_W = 3;
    localparam int SEL_W     = 3;

    // Front-of-FIFO flit type as carried on flit_id (one-hot encodings)
    typedef enum logic [FLIT_ID_W-1:0] {
        HEADER  = 3'b001,
        PAYLOAD = 3'b010,
        TAIL    = 3'b100
    } flit_id_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam logic [SEL_W-1:0] PORT_N = 3'd0;
    localparam logic [SEL_W-1:0] PORT_E = 3'd1;
    localparam logic [SEL_W-1:0] PORT_W = 3'd2;
    localparam logic [SEL_W-1:0] PORT_S = 3'd3;
    localparam logic [SEL_W-1:0] PORT_L = 3'd4;

    // Next port index after idx, wrapping the last port back to PORT_N
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx, input int n);
        if (int'(idx) >= n - 1)
            return PORT_N;
        else
            return idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// Request/grant/credit bundle between the input-side logic and one output
// arbiter. pkt_count exists only when ARB_PKT_COUNT_EN is defined.
interface output_port_arbiter_if
    import output_port_arbiter_pkg::*;
#(
    parameter int NUM_IN = 5,
    parameter int CW     = 3
);
    logic [NUM_IN-1:0]           req;
    logic [NUM_IN-1:0]           valid;
    logic [FLIT_ID_W*NUM_IN-1:0] flit_id;
    logic                        credit_in;
    logic [NUM_IN-1:0]           grant;
    logic [NUM_IN-1:0]           pop;
    logic [SEL_W-1:0]            sel;
    logic                        flit_valid_out;
    logic [CW-1:0]               credit_cnt;
`ifdef ARB_PKT_COUNT_EN
    logic [15:0]                 pkt_count;
`endif

    // Input side: drives requests/flit status, observes grants and pops
    modport master (
        output req, valid, flit_id, credit_in,
`ifdef ARB_PKT_COUNT_EN
        input  pkt_count,
`endif
        input  grant, pop, sel, flit_valid_out, credit_cnt
    );

    // Arbiter side
    modport slave (
        input  req, valid, flit_id, credit_in,
`ifdef ARB_PKT_COUNT_EN
        output pkt_count,
`endif
        output grant, pop, sel, flit_valid_out, credit_cnt
    );

endinterface

// File: rtl/output_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set candidate at or after rr_ptr,
// searching upward and wrapping. Shared by all five output arbiters.
module output_port_arbiter_rr_arbiter #(
    parameter int NUM_IN = 5,
    parameter int PW     = 3
) (
    input  logic [NUM_IN-1:0] cand,
    input  logic [PW-1:0]     rr_ptr,
    output logic [NUM_IN-1:0] pick,
    output logic              hit
);

    int            sum;
    logic [PW-1:0] idx;

    // Scan NUM_IN positions starting at rr_ptr; the first hit wins
    always_comb begin
        pick = '0;
        hit  = 1'b0;
        sum  = 0;
        idx  = '0;
        for (int off = 0; off < NUM_IN; off++) begin
            sum = int'(rr_ptr) + off;
            if (sum >= NUM_IN)
                sum = sum - NUM_IN;
            idx = sum[PW-1:0];
            if (!hit && cand[idx]) begin
                pick[idx] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Output-port switch allocator: round-robin grant on HEADER flits, lock held
// until the packet's TAIL transfers, credit-based flow control downstream.
// Optional ARB_PKT_COUNT_EN adds a 16-bit wrapping count of completed packets.
module output_port_arbiter
    import output_port_arbiter_pkg::*;
#(
    parameter int NUM_IN  = 5,
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    output_port_arbiter_if.slave  bus
);

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    arb_state_t        state, state_nxt;
    logic [NUM_IN-1:0] grant_r;
    logic [SEL_W-1:0]  sel_r;
    logic [SEL_W-1:0]  rr_ptr;
    logic [CW-1:0]     credit_r;

    logic [NUM_IN-1:0] head_mask, tail_mask, cand, pick, pop;
    logic [SEL_W-1:0]  pick_idx;
    logic              hit, pop_any, pop_tail;

    // Classify each input's front flit and form the HEADER candidate set
    always_comb begin
        head_mask = '0;
        tail_mask = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            head_mask[i] = (bus.flit_id[FLIT_ID_W*i +: FLIT_ID_W] == HEADER);
            tail_mask[i] = (bus.flit_id[FLIT_ID_W*i +: FLIT_ID_W] == TAIL);
        end
        cand = bus.req & bus.valid & head_mask;
    end

    output_port_arbiter_rr_arbiter #(
        .NUM_IN (NUM_IN),
        .PW     (SEL_W)
    ) u_rr (
        .cand   (cand),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .hit    (hit)
    );

    // Binary index of the one-hot pick, used for the crossbar select
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_IN; i++)
            if (pick[i])
                pick_idx = SEL_W'(i);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state: lock on a picked HEADER, unlock when the TAIL pops
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hit)      state_nxt = LOCKED;
            LOCKED:  if (pop_tail) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // FSM outputs: pop only the granted input, only while a credit remains
    always_comb begin
        pop = '0;
        if (state == LOCKED && credit_r != '0)
            pop = grant_r & bus.valid;
        pop_any  = |pop;
        pop_tail = |(pop & tail_mask);
    end

    // Grant/select capture on arbitration, release and pointer advance on TAIL
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_r <= '0;
            sel_r   <= '0;
            rr_ptr  <= '0;
        end else if (state == IDLE && hit) begin
            grant_r <= pick;
            sel_r   <= pick_idx;
        end else if (state == LOCKED && pop_tail) begin
            grant_r <= '0;
            rr_ptr  <= wrap_inc(sel_r, NUM_IN);
        end
    end

    // Credit counter: pop consumes, credit_in returns, saturating at CREDITS
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            credit_r <= CRED_MAX;
        else begin
            case ({bus.credit_in, pop_any})
                2'b10:   if (credit_r != CRED_MAX) credit_r <= credit_r + CW'(1);
                2'b01:   credit_r <= credit_r - CW'(1);
                default: credit_r <= credit_r;
            endcase
        end
    end

`ifdef ARB_PKT_COUNT_EN
    logic [15:0] pkt_count_r;

    // Completed-packet counter, naturally wrapping at 16 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pkt_count_r <= '0;
        else if (pop_tail)
            pkt_count_r <= pkt_count_r + 16'd1;
    end

    assign bus.pkt_count = pkt_count_r;
`endif

    assign bus.grant          = grant_r;
    assign bus.pop            = pop;
    assign bus.sel            = sel_r;
    assign bus.flit_valid_out = pop_any;
    assign bus.credit_cnt     = credit_r;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter. Per-input flit FIFOs are modelled
// as queues; each issued packet pushes its expected pop sequence (input index)
// into a scoreboard that the negedge monitor drains on every flit transfer.
module tb_output_port_arbiter;
    import output_port_arbiter_pkg::*;

    localparam int NUM_IN  = 5;
    localparam int CREDITS = 4;
    localparam int CW      = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    output_port_arbiter_if #(.NUM_IN(NUM_IN), .CW(CW)) bus();

    output_port_arbiter #(
        .NUM_IN  (NUM_IN),
        .CREDITS (CREDITS),
        .CW      (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [2:0]        fq [NUM_IN][$];
    logic [NUM_IN-1:0] hold     = '0;
    logic [NUM_IN-1:0] pop_seen = '0;
    int                exp_q[$];
    int                e;
    int                n_chk  = 0;
    int                n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NUM_IN-1:0] oh(input int i);
        return NUM_IN'(1) << i;
    endfunction

    function automatic bit busy();
        for (int i = 0; i < NUM_IN; i++)
            if (fq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NUM_IN; i++) begin
            bus.valid[i] = (fq[i].size() != 0) && !hold[i];
            bus.flit_id[3*i +: 3] = (fq[i].size() != 0) ? fq[i][0] : PAYLOAD;
        end
    endtask

    // Advance one cycle: retire flits popped at the last edge, re-present fronts
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_IN; i++)
            if (pop_seen[i] && fq[i].size() != 0)
                void'(fq[i].pop_front());
        drive_inputs();
    endtask

    task automatic push_pkt(input int port, input int len, input bit with_exp);
        fq[port].push_back(HEADER);
        for (int k = 0; k < len - 2; k++)
            fq[port].push_back(PAYLOAD);
        fq[port].push_back(TAIL);
        if (with_exp)
            for (int k = 0; k < len; k++)
                exp_q.push_back(port);
    endtask

    task automatic reset_dut();
        rst           = 1'b0;
        bus.req       = '0;
        bus.credit_in = 1'b0;
        hold          = '0;
        for (int i = 0; i < NUM_IN; i++)
            fq[i].delete();
        drive_inputs();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic run_until_empty(input string name);
        for (int k = 0; k < 200 && busy(); k++)
            step();
        chk(name, 32'(busy()), 32'd0);
    endtask

    // Scoreboard monitor: every transferred flit must match the next expectation
    always @(negedge clk) begin
        pop_seen = bus.pop;
        if (bus.flit_valid_out) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: pop=%b sel=%0d with nothing expected", bus.pop, bus.sel);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pop", 32'(bus.pop), 32'(oh(e)));
                chk("sb_sel", 32'(bus.sel), 32'(e));
            end
        end
    end

    initial begin
        rst           = 1'b0;
        bus.req       = '0;
        bus.valid     = '0;
        bus.flit_id   = '0;
        bus.credit_in = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_grant",  32'(bus.grant), 32'd0);
        chk("rst_sel",    32'(bus.sel), 32'd0);
        chk("rst_credit", 32'(bus.credit_cnt), 32'd4);
        chk("rst_pop",    32'(bus.pop), 32'd0);
        chk("rst_fvo",    32'(bus.flit_valid_out), 32'd0);

        // Basic single packet on N
        reset_dut();
        push_pkt(PORT_N, 3, 1'b1);
        bus.req[PORT_N] = 1'b1;
        drive_inputs();
        @(negedge clk);
        chk("basic_grant_lat", 32'(bus.grant), 32'd0);
        chk("basic_pop_idle",  32'(bus.pop), 32'd0);
        step();
        @(negedge clk);
        chk("basic_grant",   32'(bus.grant), 32'b00001);
        chk("basic_credit0", 32'(bus.credit_cnt), 32'd4);
        step();
        step();
        @(negedge clk);
        chk("basic_credit_tail", 32'(bus.credit_cnt), 32'd2);
        step();
        @(negedge clk);
        chk("basic_grant_rel", 32'(bus.grant), 32'd0);
        chk("basic_credit_end", 32'(bus.credit_cnt), 32'd1);
        chk("basic_pop_end", 32'(bus.pop), 32'd0);
        bus.req = '0;
        bus.credit_in = 1'b1;
        repeat (4) step();
        bus.credit_in = 1'b0;
        @(negedge clk);
        chk("credit_saturate", 32'(bus.credit_cnt), 32'd4);

        // Round-robin fairness: N, W, L with two 2-flit packets each
        reset_dut();
        bus.credit_in = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push_pkt(PORT_N, 2, 1'b0);
            push_pkt(PORT_W, 2, 1'b0);
            push_pkt(PORT_L, 2, 1'b0);
        end
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(PORT_N); exp_q.push_back(PORT_N);
            exp_q.push_back(PORT_W); exp_q.push_back(PORT_W);
            exp_q.push_back(PORT_L); exp_q.push_back(PORT_L);
        end
        bus.req = 5'b10101;
        drive_inputs();
        run_until_empty("rr_done");
        bus.req = '0;
        step();
        bus.credit_in = 1'b0;
        @(negedge clk);
        chk("rr_idle_grant", 32'(bus.grant), 32'd0);
        chk("rr_credit", 32'(bus.credit_cnt), 32'd4);

        // Credit stall with a 6-flit packet on E
        reset_dut();
        push_pkt(PORT_E, 6, 1'b1);
        bus.req[PORT_E] = 1'b1;
        drive_inputs();
        repeat (5) step();
        @(negedge clk);
        chk("stall_pop",    32'(bus.pop), 32'd0);
        chk("stall_grant",  32'(bus.grant), 32'b00010);
        chk("stall_credit", 32'(bus.credit_cnt), 32'd0);
        step();
        step();
        @(negedge clk);
        chk("stall_pop_hold",   32'(bus.pop), 32'd0);
        chk("stall_grant_hold", 32'(bus.grant), 32'b00010);
        step();
        bus.credit_in = 1'b1;
        step();
        bus.credit_in = 1'b0;
        @(negedge clk);
        chk("one_credit_pop", 32'(bus.pop), 32'b00010);
        chk("one_credit_cnt", 32'(bus.credit_cnt), 32'd1);
        step();
        @(negedge clk);
        chk("restall_pop",   32'(bus.pop), 32'd0);
        chk("restall_grant", 32'(bus.grant), 32'b00010);

        // Simultaneous pop and credit return on the TAIL
        bus.credit_in = 1'b1;
        step();
        @(negedge clk);
        chk("simul_pop", 32'(bus.pop), 32'b00010);
        chk("simul_cnt_before", 32'(bus.credit_cnt), 32'd1);
        step();
        @(negedge clk);
        chk("simul_cnt_after", 32'(bus.credit_cnt), 32'd1);
        chk("simul_grant_rel", 32'(bus.grant), 32'd0);
        repeat (4) step();
        bus.credit_in = 1'b0;
        @(negedge clk);
        chk("sat_at_max", 32'(bus.credit_cnt), 32'd4);

        // Input FIFO empty mid-packet on S
        reset_dut();
        push_pkt(PORT_S, 4, 1'b1);
        bus.req[PORT_S] = 1'b1;
        drive_inputs();
        step();
        step();
        hold[PORT_S] = 1'b1;
        drive_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("empty_grant", 32'(bus.grant), 32'b01000);
            chk("empty_pop",   32'(bus.pop), 32'd0);
            step();
        end
        hold[PORT_S] = 1'b0;
        drive_inputs();
        repeat (3) step();
        @(negedge clk);
        chk("empty_done_grant",  32'(bus.grant), 32'd0);
        chk("empty_done_credit", 32'(bus.credit_cnt), 32'd0);

        // Asynchronous reset mid-packet on L
        reset_dut();
        push_pkt(PORT_L, 4, 1'b0);
        exp_q.push_back(PORT_L);
        exp_q.push_back(PORT_L);
        bus.req[PORT_L] = 1'b1;
        drive_inputs();
        repeat (3) step();
        #2;
        rst = 1'b0;
        #1;
        chk("async_grant",  32'(bus.grant), 32'd0);
        chk("async_credit", 32'(bus.credit_cnt), 32'd4);
        chk("async_pop",    32'(bus.pop), 32'd0);
        chk("async_sel",    32'(bus.sel), 32'd0);
        fq[PORT_L].delete();
        bus.req = '0;
        drive_inputs();
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("post_rst_grant", 32'(bus.grant), 32'd0);

`ifdef ARB_PKT_COUNT_EN
        // Completed-packet counter and its wrap
        reset_dut();
        bus.credit_in = 1'b1;
        for (int k = 0; k < 3; k++)
            push_pkt(PORT_W, 2, 1'b1);
        bus.req[PORT_W] = 1'b1;
        drive_inputs();
        run_until_empty("pkt_done");
        step();
        @(negedge clk);
        chk("pkt_count3", 32'(bus.pkt_count), 32'd3);
        force dut.pkt_count_r = 16'hFFFF;
        step();
        release dut.pkt_count_r;
        push_pkt(PORT_W, 2, 1'b1);
        drive_inputs();
        run_until_empty("pkt_wrap_done");
        step();
        @(negedge clk);
        chk("pkt_count_wrap", 32'(bus.pkt_count), 32'd0);
        bus.credit_in = 1'b0;
        bus.req = '0;
`endif

        step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
